// File: rtl/snake_input_ctrl_if.sv
// Button inputs, halt and heading/step outputs of the snake input controller.
// Master drives the buttons and halt; the controller is the slave.
interface snake_input_ctrl_if;
    logic       BtnU;
    logic       BtnD;
    logic       BtnL;
    logic       BtnR;
    logic       BtnC;
    logic       halt;
    logic [1:0] dir;
    logic       step;
    logic       paused;
    logic       pend_valid;

    modport master (
        output BtnU, BtnD, BtnL, BtnR, BtnC, halt,
        input  dir, step, paused, pend_valid
    );

    modport slave (
        input  BtnU, BtnD, BtnL, BtnR, BtnC, halt,
        output dir, step, paused, pend_valid
    );
endinterface

// File: rtl/snake_input_ctrl.sv
// Debounces the board buttons, queues heading changes, owns pause and emits the game step strobe.
// Latency: a held button becomes a press DB_CYCLES+3 edges after first sampling; requests apply on the next step.
// No backpressure: inputs are sampled every cycle and step is a one-cycle strobe the core must take.
module snake_input_ctrl #(
    parameter logic [19:0] DB_CYCLES   = 20'd1000000,
    parameter logic [25:0] TICK_CYCLES = 26'd25000000
) (
    input  logic              board_clk,
    input  logic              reset,
    snake_input_ctrl_if.slave io
);
    localparam logic [19:0] DB_LAST   = DB_CYCLES - 20'd1;
    localparam logic [25:0] TICK_LAST = TICK_CYCLES - 26'd1;
    localparam int BU = 0;
    localparam int BD = 1;
    localparam int BL = 2;
    localparam int BR = 3;
    localparam int BC = 4;

    logic [4:0]       btn_raw;
    logic [4:0]       s1_q, s1_d, s2_q, s2_d;
    logic [4:0]       stab_q, stab_d, stab_r_q, stab_r_d, stab_rr_q, stab_rr_d;
    logic [4:0]       press_q, press_d;
    logic [4:0][19:0] cnt_q, cnt_d;
    logic [25:0]      tcnt_q, tcnt_d;
    logic             step_q, step_d;
    logic             paused_q, paused_d;
    logic             pend_vld_q, pend_vld_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pend_q, pend_d;
    logic             req_vld;
    logic [1:0]       req_dir;
    logic             req_ok;
    logic             running;

    assign btn_raw = {io.BtnC, io.BtnR, io.BtnL, io.BtnD, io.BtnU};

    always_comb begin
        s1_d   = btn_raw;
        s2_d   = s1_q;
        stab_d = stab_q;
        cnt_d  = cnt_q;
        for (int b = 0; b < 5; b++) begin
            if (s2_q[b] != stab_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    stab_d[b] = s2_q[b];
                    cnt_d[b]  = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 20'd1;
                end
            end else begin
                cnt_d[b] = '0;
            end
        end
        // Extra retiming stage places the press pulse DB_CYCLES+3 edges after the input is first sampled.
        stab_r_d  = stab_q;
        stab_rr_d = stab_r_q;
        press_d   = stab_r_q & ~stab_rr_q;
    end

    always_comb begin
        req_vld = |press_q[BR:BU];
        req_dir = 2'b11;
        if (press_q[BU]) begin
            req_dir = 2'b00;
        end else if (press_q[BD]) begin
            req_dir = 2'b01;
        end else if (press_q[BL]) begin
            req_dir = 2'b10;
        end
        // Heading codes pair up so that flipping bit 0 gives the opposite heading.
        req_ok = req_vld && (req_dir != dir_q) && (req_dir != (dir_q ^ 2'b01));
    end

    always_comb begin
        running    = ~paused_q & ~io.halt;
        tcnt_d     = tcnt_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        paused_d   = paused_q;

        if (running) begin
            if (tcnt_q == TICK_LAST) begin
                tcnt_d = '0;
                step_d = 1'b1;
                if (pend_vld_q) begin
                    dir_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + 26'd1;
            end
        end else begin
            tcnt_d = '0;
        end

        // A request landing on a step edge must survive that step, so it is applied after the step.
        if (req_ok) begin
            pend_d     = req_dir;
            pend_vld_d = 1'b1;
        end

        if (io.halt) begin
            paused_d = 1'b1;
        end else if (press_q[BC]) begin
            paused_d = ~paused_q;
            if (!paused_q) begin
                tcnt_d = '0;
            end
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stab_q     <= '0;
            stab_r_q   <= '0;
            stab_rr_q  <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            step_q     <= 1'b0;
            paused_q   <= 1'b1;
            pend_vld_q <= 1'b0;
            dir_q      <= 2'b11;
            pend_q     <= 2'b00;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            stab_q     <= stab_d;
            stab_r_q   <= stab_r_d;
            stab_rr_q  <= stab_rr_d;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            step_q     <= step_d;
            paused_q   <= paused_d;
            pend_vld_q <= pend_vld_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
        end
    end

    assign io.dir        = dir_q;
    assign io.step       = step_q;
    assign io.paused     = paused_q;
    assign io.pend_valid = pend_vld_q;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed vector table, hand sequences for bounce/halt, then random
// traffic, with every cycle also compared against a behavioural model of the game input rules.
module tb_snake_input_ctrl;
    localparam int DB = 4;
    localparam int TK = 8;
    localparam bit [4:0] U = 5'b00001;
    localparam bit [4:0] D = 5'b00010;
    localparam bit [4:0] L = 5'b00100;
    localparam bit [4:0] R = 5'b01000;
    localparam bit [4:0] C = 5'b10000;

    logic board_clk = 1'b0;
    logic reset;

    snake_input_ctrl_if io ();

    snake_input_ctrl #(
        .DB_CYCLES   (20'd4),
        .TICK_CYCLES (26'd8)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .io        (io)
    );

    always #5 board_clk = ~board_clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int step_seen = 0;
    int pend_seen = 0;

    // Behavioural model state
    bit       m_live = 1'b0;
    bit [4:0] m_sync[$];
    int       m_run[5];
    bit [4:0] m_stab;
    int       m_rise[5];
    int       m_dir;
    int       m_pend;
    bit       m_pend_vld;
    bit       m_paused;
    bit       m_step;
    int       m_tcnt;
    int       opp[4] = '{1, 0, 3, 2};

    task automatic model_edge(input bit [4:0] btn, input bit h, input bit rst, input int n);
        bit [4:0] seen;
        bit [4:0] press;
        int       win;
        int       old_dir;
        bit       old_paused;
        if (rst) begin
            m_live = 1'b1;
            m_sync.delete();
            m_sync.push_back(5'b0);
            m_sync.push_back(5'b0);
            for (int b = 0; b < 5; b++) begin
                m_run[b]  = 0;
                m_rise[b] = -100;
            end
            m_stab = '0; m_dir = 3; m_pend = 0; m_pend_vld = 0;
            m_paused = 1; m_step = 0; m_tcnt = 0;
            return;
        end
        if (!m_live) return;
        old_dir = m_dir;
        old_paused = m_paused;
        // A debounced rise at edge f is seen as a press by the logic at edge f+3.
        for (int b = 0; b < 5; b++) press[b] = (m_rise[b] + 3 == n);
        seen = m_sync.pop_front();
        m_sync.push_back(btn);
        for (int b = 0; b < 5; b++) begin
            if (seen[b] != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_stab[b] = seen[b];
                    m_run[b]  = 0;
                    if (seen[b]) m_rise[b] = n;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_step = 0;
        if (!old_paused && !h) begin
            if (m_tcnt == TK - 1) begin
                m_tcnt = 0;
                m_step = 1;
                if (m_pend_vld) begin
                    m_dir = m_pend;
                    m_pend_vld = 0;
                end
            end else begin
                m_tcnt++;
            end
        end else begin
            m_tcnt = 0;
        end
        win = -1;
        for (int b = 3; b >= 0; b--) if (press[b]) win = b;
        if (win >= 0 && win != old_dir && win != opp[old_dir]) begin
            m_pend = win;
            m_pend_vld = 1;
        end
        if (h) begin
            m_paused = 1;
        end else if (press[4]) begin
            if (!old_paused) m_tcnt = 0;
            m_paused = !old_paused;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cyc(input bit [4:0] btn, input bit h, input bit rst);
        {io.BtnC, io.BtnR, io.BtnL, io.BtnD, io.BtnU} = btn;
        io.halt = h;
        reset   = rst;
        @(posedge board_clk);
        model_edge(btn, h, rst, edge_n);
        edge_n++;
        @(negedge board_clk);
        if (m_live) begin
            checks++;
            if (int'(io.dir) != m_dir || io.step !== m_step || io.paused !== m_paused ||
                io.pend_valid !== m_pend_vld) begin
                errors++;
                $display("FAIL model edge %0d: got dir=%0d step=%b paused=%b pend_valid=%b, expected dir=%0d step=%b paused=%b pend_valid=%b",
                         edge_n - 1, io.dir, io.step, io.paused, io.pend_valid,
                         m_dir, m_step, m_paused, m_pend_vld);
            end
        end
        if (io.step === 1'b1) step_seen++;
        if (io.pend_valid === 1'b1) pend_seen++;
    endtask

    typedef struct {
        bit [4:0] btn;
        bit       h;
        bit       rst;
        int       n;
        int       e_dir;
        bit       e_paused;
        bit       e_pend;
        int       e_steps;
    } vec_t;

    vec_t tbl[11];

    initial begin
        {io.BtnC, io.BtnR, io.BtnL, io.BtnD, io.BtnU} = 5'b0;
        io.halt = 1'b0;
        reset   = 1'b1;

        // Each row: inputs held n cycles, then heading/paused/pend and step count over the row.
        tbl[0]  = '{5'b0,  0, 1, 2,  3, 1, 0, 0};  // reset values
        tbl[1]  = '{U,     0, 0, 12, 3, 1, 1, 0};  // U queued while paused
        tbl[2]  = '{5'b0,  0, 0, 6,  3, 1, 1, 0};  // release is not a press
        tbl[3]  = '{C,     0, 0, 6,  3, 1, 1, 0};  // pause toggle still in flight
        tbl[4]  = '{5'b0,  0, 0, 12, 0, 0, 0, 1};  // resume, first step applies U
        tbl[5]  = '{L,     0, 0, 6,  0, 0, 0, 0};
        tbl[6]  = '{5'b0,  0, 0, 10, 2, 0, 0, 2};  // L applied on second step
        tbl[7]  = '{R,     0, 0, 6,  2, 0, 0, 0};
        tbl[8]  = '{5'b0,  0, 0, 10, 2, 0, 0, 2};  // R rejected as reversal of L
        tbl[9]  = '{U | L, 0, 0, 6,  2, 0, 0, 0};
        tbl[10] = '{5'b0,  0, 0, 10, 0, 0, 0, 2};  // U beats L

        for (int i = 0; i < 11; i++) begin
            step_seen = 0;
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].btn, tbl[i].h, tbl[i].rst);
            chk($sformatf("vec%0d dir", i), int'(io.dir), tbl[i].e_dir);
            chk($sformatf("vec%0d paused", i), int'(io.paused), int'(tbl[i].e_paused));
            chk($sformatf("vec%0d pend_valid", i), int'(io.pend_valid), int'(tbl[i].e_pend));
            chk($sformatf("vec%0d steps", i), step_seen, tbl[i].e_steps);
        end

        // Bounce on L with 2-cycle runs never reaches the debounce threshold.
        pend_seen = 0;
        for (int k = 0; k < 20; k++) cyc(((k / 2) % 2 == 0) ? L : 5'b0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(5'b0, 0, 0);
        chk("bounce pend_valid seen", pend_seen, 0);
        chk("bounce dir", int'(io.dir), 0);

        // Halt mid-count: paused forced, no steps, BtnC ignored, resume only via BtnC.
        step_seen = 0;
        cyc(5'b0, 1, 0);
        chk("halt paused", int'(io.paused), 1);
        for (int k = 0; k < 24; k++) cyc((k < 6) ? C : 5'b0, 1, 0);
        chk("halt steps", step_seen, 0);
        chk("halt paused held", int'(io.paused), 1);
        for (int k = 0; k < 10; k++) cyc(5'b0, 0, 0);
        chk("halt release paused", int'(io.paused), 1);
        chk("halt release steps", step_seen, 0);
        begin
            int k;
            k = 0;
            while (k < 40) begin
                cyc((k < 6) ? C : 5'b0, 0, 0);
                if (io.step === 1'b1) break;
                k++;
            end
            chk("resume step edge", k, 16);
        end

        // Reset mid-count drops everything in flight.
        cyc(L, 0, 0);
        cyc(L, 0, 1);
        chk("mid reset dir", int'(io.dir), 3);
        chk("mid reset step", int'(io.step), 0);
        chk("mid reset paused", int'(io.paused), 1);

        // Random traffic against the model.
        begin
            bit [4:0] btn;
            bit       h;
            btn = '0;
            h   = 0;
            for (int k = 0; k < 3000; k++) begin
                for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) btn[b] = ~btn[b];
                if ($urandom_range(11) == 0) btn[4] = ~btn[4];
                if ($urandom_range(59) == 0) h = ~h;
                cyc(btn, h, ($urandom_range(499) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
